// File: rtl/indexed_fetch_pkg.sv
// ============================================================================
// Module : indexed_fetch_pkg
// Brief  : Processor-wide control-unit command codes and fetch FSM encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package indexed_fetch_pkg;

    localparam logic [4:0] CS_LOAD_IX  = 5'b11010;
    localparam logic [4:0] CS_INC_IX   = 5'b11011;
    localparam logic [4:0] CS_FETCH_IX = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/indexed_fetch_if.sv
// ============================================================================
// Module : indexed_fetch_if
// Brief  : Control-unit, index-register and memory-port signals of the fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface indexed_fetch_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [4:0]        cs;
    logic [ADDR_W-1:0] pcontrol;
    logic [ADDR_W-1:0] ix;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              err;
    logic              ix_inc;

    // master: the fetch unit itself (it is the bus master on the memory port)
    modport master (
        input  cs, pcontrol, ix, mem_ready, mem_rdata,
        output mem_addr, mem_rd, data_out, data_valid, busy, err, ix_inc
    );

    modport slave (
        output cs, pcontrol, ix, mem_ready, mem_rdata,
        input  mem_addr, mem_rd, data_out, data_valid, busy, err, ix_inc
    );
endinterface

`default_nettype wire

// File: rtl/indexed_fetch_wait_timer.sv
// ============================================================================
// Module : indexed_fetch_wait_timer
// Brief  : Fetch wait timer; counts unanswered REQ cycles, expired at WAIT_MAX-1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module indexed_fetch_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/indexed_fetch.sv
// ============================================================================
// Module : indexed_fetch
// Brief  : Indexed read fetch, EA = pcontrol + ix, with ready handshake and timeout.
//          Optional macro FETCH_POSTINC_EN enables the ix_inc post-increment pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module indexed_fetch
    import indexed_fetch_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter int unsigned WAIT_MAX = 15
) (
    input  wire logic           clk,
    input  wire logic           reset,
    indexed_fetch_if.master     bus
);
    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] data_q;

    logic load_ea;
    logic capture;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;
    logic rd_req;
    logic busy_q;
    logic valid_pulse;
    logic err_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_ea     = 1'b0;
        capture     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        rd_req      = 1'b0;
        busy_q      = 1'b0;
        valid_pulse = 1'b0;
        err_pulse   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cs == CS_FETCH_IX) begin
                    load_ea     = 1'b1;
                    timer_clear = 1'b1;
                    state_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                rd_req = 1'b1;
                busy_q = 1'b1;
                if (bus.mem_ready) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DONE: begin
                busy_q      = 1'b1;
                valid_pulse = 1'b1;
                state_next  = ST_IDLE;
            end
            ST_ERR: begin
                busy_q     = 1'b1;
                err_pulse  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands are captured only at the command edge; later changes of ix are invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            ea     <= '0;
            data_q <= '0;
        end else begin
            if (load_ea) begin
                ea <= bus.pcontrol + bus.ix;
            end
            if (capture) begin
                data_q <= bus.mem_rdata;
            end
        end
    end

    indexed_fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    assign bus.mem_addr   = ea;
    assign bus.mem_rd     = rd_req;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_pulse;
    assign bus.busy       = busy_q;
    assign bus.err        = err_pulse;

`ifdef FETCH_POSTINC_EN
    assign bus.ix_inc = valid_pulse;
`else
    assign bus.ix_inc = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_indexed_fetch.sv
// ============================================================================
// Module : tb_indexed_fetch
// Brief  : Self-checking bench for indexed_fetch (directed + randomized fetches).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_indexed_fetch;
    import indexed_fetch_pkg::*;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;
    localparam int WAIT_MAX = 15;
`ifdef FETCH_POSTINC_EN
    localparam bit POSTINC = 1'b1;
`else
    localparam bit POSTINC = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_data = 8'h00;

    indexed_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    indexed_fetch #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] idle_cs();
        logic [4:0] c;
        c = 5'($urandom);
        if (c == CS_FETCH_IX) c = CS_INC_IX;
        return c;
    endfunction

    // One command starting in IDLE; d = REQ-cycle index in which ready is given
    // (d >= WAIT_MAX means memory never answers).
    task automatic run_fetch(input logic [7:0] ix_v, input logic [7:0] pc_v, input int d,
                             input logic [7:0] rd_v, input bit reissue, input bit ready_always);
        int         exp_addr, exp_rd;
        bit         ok, go;
        int         rd_cycles = 0, first_rd = -1, dv = 0, dv_cyc = -1, rdy_cyc = -1;
        int         er = 0, last_busy = -1, bad_addr = 0, bad_inc = 0, bad_hold = 0;
        logic [7:0] old, exp_hold;
        exp_addr = (int'(ix_v) + int'(pc_v)) % 256;
        ok       = (d < WAIT_MAX);
        exp_rd   = ok ? d + 1 : WAIT_MAX;
        old      = exp_data;

        bus.cs        = CS_FETCH_IX;
        bus.ix        = ix_v;
        bus.pcontrol  = pc_v;
        bus.mem_ready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        for (int cyc = 1; cyc <= WAIT_MAX + 4; cyc++) begin
            tick();
            if (bus.mem_rd === 1'b1) begin
                rd_cycles++;
                if (first_rd < 0) first_rd = cyc;
                if (bus.mem_addr !== 8'(exp_addr)) bad_addr++;
            end
            if (bus.data_valid === 1'b1) begin
                dv++;
                dv_cyc = cyc;
            end
            if (bus.err === 1'b1) er++;
            if (bus.ix_inc !== (POSTINC & bus.data_valid)) bad_inc++;
            if (bus.busy === 1'b1) last_busy = cyc;
            exp_hold = (ok && cyc >= d + 2) ? rd_v : old;
            if (bus.data_out !== exp_hold) bad_hold++;

            bus.ix       = 8'($urandom);
            bus.pcontrol = 8'($urandom);
            bus.cs       = (reissue && bus.busy === 1'b1) ? CS_FETCH_IX : idle_cs();
            if (bus.mem_rd === 1'b1) begin
                go = ready_always || (rd_cycles - 1 == d);
                if (go && rdy_cyc < 0) rdy_cyc = cyc;
            end else begin
                go = ready_always || 1'($urandom_range(0, 1));
            end
            bus.mem_ready = go;
            bus.mem_rdata = (bus.mem_rd === 1'b1 && go) ? rd_v : 8'($urandom);
        end
        bus.cs        = idle_cs();
        bus.mem_ready = 1'b0;

        chk("first_rd_cycle", first_rd, 1);
        chk("rd_cycles", rd_cycles, exp_rd);
        chk("addr_errors", bad_addr, 0);
        chk("valid_pulses", dv, ok ? 1 : 0);
        chk("err_pulses", er, ok ? 0 : 1);
        chk("busy_last_cycle", last_busy, exp_rd + 1);
        chk("data_hold_errors", bad_hold, 0);
        chk("ix_inc_errors", bad_inc, 0);
        if (ok) begin
            chk("valid_latency", dv_cyc, rdy_cyc + 1);
            exp_data = rd_v;
        end
        chk("data_out", bus.data_out, exp_data);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_data_out"}, bus.data_out, 0);
        chk({tag, "_data_valid"}, bus.data_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_ix_inc"}, bus.ix_inc, 0);
    endtask

    initial begin
        int activity;
        bus.cs        = 5'd0;
        bus.ix        = 8'd0;
        bus.pcontrol  = 8'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'd0;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("post_reset_busy", bus.busy, 0);

        // basic fetch, ready in the third REQ cycle
        run_fetch(8'h10, 8'h05, 2, 8'hA5, 1'b0, 1'b0);

        // address wrap with ready already high in IDLE
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        chk("idle_ready_no_rd", bus.mem_rd, 0);
        run_fetch(8'hF0, 8'h20, 0, 8'h3C, 1'b0, 1'b1);

        // timeout: memory never answers
        run_fetch(8'($urandom), 8'($urandom), WAIT_MAX + 5, 8'h77, 1'b0, 1'b0);

        // non-fetch codes cause no activity
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cs        = (i % 3 == 0) ? CS_LOAD_IX : ((i % 3 == 1) ? CS_INC_IX : idle_cs());
            bus.mem_ready = 1'($urandom_range(0, 1));
            tick();
            if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.data_valid !== 1'b0 ||
                bus.err !== 1'b0 || bus.data_out !== exp_data) activity++;
        end
        chk("non_fetch_activity", activity, 0);
        bus.mem_ready = 1'b0;

        // command re-issued while busy
        run_fetch(8'h01, 8'h02, 4, 8'h5A, 1'b1, 1'b0);
        run_fetch(8'h80, 8'h80, WAIT_MAX + 1, 8'h11, 1'b1, 1'b0);

        // randomized fetches
        for (int i = 0; i < 20; i++) begin
            run_fetch(8'($urandom), 8'($urandom), int'($urandom_range(0, WAIT_MAX + 2)),
                      8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // reset in the second REQ cycle
        bus.cs       = CS_FETCH_IX;
        bus.ix       = 8'h33;
        bus.pcontrol = 8'h44;
        tick();
        bus.cs = idle_cs();
        tick();
        chk("pre_reset_mem_rd", bus.mem_rd, 1);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset    = 1'b0;
        exp_data = 8'h00;
        tick();
        chk("after_reset_idle", bus.busy, 0);
        run_fetch(8'h0F, 8'hF1, 1, 8'hC3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
